core_dmem_responder: RTL and testbench
======================================

# core_dmem_responder

Data-memory responder that sits on the far side of the core's `dmem_*` request/grant bus and terminates transactions issued by the execute-stage LSU. It decodes the request address against a configurable window and performs byte-strobed writes or full-width reads on an internal single-port word array. After a programmable number of wait states it returns a one-cycle grant carrying read data and an error flag. It serves as the tightly-coupled data RAM in integration and as the bus model in core-level benches.

## Interface
Parameters:
- `DEPTH`, 1024: number of 64-bit words in the array; must be a power of two.
- `BASE`, 64'h0000_0000_0001_0000: first byte address of the window; must be aligned to `DEPTH*8`.
- `WAIT_CYCLES`, 0: wait states inserted between request capture and grant; range 0..15.

Ports:
- `g_clk`  in  1  global clock.
- `g_resetn`  in  1  asynchronous, active-low reset.
- `dmem_req`  in  1  request valid; held with all request fields stable until `dmem_gnt`.
- `dmem_addr`  in  `MEM_ADDR_R+1`  byte address.
- `dmem_wen`  in  1  1 = write, 0 = read.
- `dmem_strb`  in  `MEM_STRB_R+1`  write byte enables; bit i enables byte lane i.
- `dmem_wdata`  in  `MEM_DATA_R+1`  write data.
- `dmem_gnt`  out  1  one-cycle response valid; transaction complete.
- `dmem_err`  out  1  response error; valid only when `dmem_gnt` is high.
- `dmem_rdata`  out  `MEM_DATA_R+1`  read data; valid only when `dmem_gnt` is high and `dmem_wen` was 0.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On `dmem_req` = 1, capture `wen`, `strb`, `wdata`, `addr` and the decoded hit.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES` > 0, otherwise go to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - If `dmem_req` drops, go to IDLE (protocol violation). No grant is issued and no array write occurs.
- RESP:
  - `dmem_gnt` = 1 for exactly one cycle, then unconditionally go to IDLE.
  - A new request is sampled no earlier than the IDLE cycle that follows.
- Address decode:
  - offset = `dmem_addr` − `BASE`, computed in full width.
  - hit = (`dmem_addr` ≥ `BASE`) and (offset < `DEPTH*8`).
  - Word index = offset[3 +: log2(DEPTH)]; `dmem_addr[2:0]` is ignored because lane selection is the initiator's responsibility via `strb`.
- Array access happens at the clock edge that enters RESP:
  - Write with hit: update byte lanes where `strb[i]` = 1; other lanes are unchanged.
  - Read with hit: register the array word into `dmem_rdata`.
  - Miss: no array access, `dmem_err` = 1, `dmem_rdata` = 0.
- Write responses: `dmem_rdata` = 0.
- A write with `strb` = 0 and hit is a legal no-op with `dmem_err` = 0.
- Array contents are not reset.

## Timing
- Reset (async assert, sync deassert): state = IDLE, `dmem_gnt` = 0, `dmem_err` = 0, `dmem_rdata` = 0, wait counter = 0.
- Reset asserted mid-transaction abandons the transaction. An array write is lost unless its RESP-entry edge has already occurred.
- Request at cycle 0 (IDLE): `dmem_gnt` is asserted in cycle 1 + `WAIT_CYCLES`.
- Back-to-back throughput: one transaction per 2 + `WAIT_CYCLES` cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- Read-after-write to the same word: the read returns the newly written data.
- Outside RESP: `dmem_gnt` = 0, `dmem_err` = 0, `dmem_rdata` = 0.

## Structure
- Bus widths `MEM_ADDR_R`, `MEM_DATA_R`, `MEM_STRB_R` and `XL` come from the shared `core_common.vh`.
- FSM state encodings are local to this block.
- One sub-module, `core_dmem_sram`: a synchronous single-port array with byte-write enables and a registered read port, holding no control logic. The FSM, decode and counter live in the parent.
- Estimated size: ~180 lines of RTL total.

## Test plan
- Reset then idle: `g_resetn` low for 3 cycles, then high with `dmem_req` = 0 for 10 cycles -> `dmem_gnt`, `dmem_err` and `dmem_rdata` stay 0 throughout.
- Full write then read, `WAIT_CYCLES` = 0:
  - Write addr 0x10008, strb 0xFF, wdata 0x1122334455667788 -> grant in cycle 1, err 0.
  - Read the same address -> grant in cycle 1, rdata 0x1122334455667788.
- Partial strobe: over the word above, write strb 0x0F with wdata 0xAAAAAAAA_BBBBBBBB, then read -> rdata 0x11223344BBBBBBBB.
- Out of window:
  - Read addr 0x0FFF8 -> grant, err 1, rdata 0.
  - Write addr `BASE` + `DEPTH*8` -> grant, err 1; a subsequent read of the last in-range word is unchanged.
- Wait states, `WAIT_CYCLES` = 3: request at cycle 0 -> `dmem_gnt` high only in cycle 4; back-to-back requests are granted at cycles 4 and 9.
- Abort and reset:
  - `WAIT_CYCLES` = 3, drop `dmem_req` in cycle 2 of a write -> no grant; a later read returns the old data.
  - Assert `g_resetn` low during WAIT -> outputs go to 0 immediately and state returns to IDLE.

Source files
------------

// File: rtl/core_dmem_responder_pkg.sv
// Shared bus widths, FSM encoding and byte-lane helper for the data-memory responder.
package core_dmem_responder_pkg;

    localparam int MEM_ADDR_R = 63;
    localparam int MEM_DATA_R = 63;
    localparam int MEM_STRB_R = 7;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    function automatic logic [MEM_DATA_R:0] merge_lanes(
        input logic [MEM_DATA_R:0] old_word,
        input logic [MEM_DATA_R:0] new_word,
        input logic [MEM_STRB_R:0] strb
    );
        logic [MEM_DATA_R:0] w;
        w = old_word;
        for (int i = 0; i <= MEM_STRB_R; i++) begin
            if (strb[i]) begin
                w[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/core_dmem_sram.sv
// Single-port word array with byte-lane write enables and a registered read port.
module core_dmem_sram
    import core_dmem_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic                wen_i,
    input  logic [AW-1:0]       idx_i,
    input  logic [MEM_STRB_R:0] strb_i,
    input  logic [MEM_DATA_R:0] wdata_i,
    output logic [MEM_DATA_R:0] rdata_o
);

    logic [MEM_DATA_R:0] mem_q [DEPTH];
    logic [MEM_DATA_R:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (wen_i) begin
                mem_q[idx_i] <= merge_lanes(mem_q[idx_i], wdata_i, strb_i);
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/core_dmem_responder.sv
// Data-memory responder: window decode, wait-state sequencing and one-cycle grant.
//   state   | meaning
//   ST_IDLE | waiting for dmem_req; captures the request
//   ST_WAIT | counting wait states; dropping dmem_req abandons the transaction
//   ST_RESP | dmem_gnt high for one cycle with err/rdata
module core_dmem_responder
    import core_dmem_responder_pkg::*;
#(
    parameter int                  DEPTH       = 1024,
    parameter logic [MEM_ADDR_R:0] BASE        = 64'h0000_0000_0001_0000,
    parameter int                  WAIT_CYCLES = 0
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    input  logic                dmem_req,
    input  logic [MEM_ADDR_R:0] dmem_addr,
    input  logic                dmem_wen,
    input  logic [MEM_STRB_R:0] dmem_strb,
    input  logic [MEM_DATA_R:0] dmem_wdata,
    output logic                dmem_gnt,
    output logic                dmem_err,
    output logic [MEM_DATA_R:0] dmem_rdata
);

    localparam int                  AW      = $clog2(DEPTH);
    localparam logic [MEM_ADDR_R:0] SPAN    = (MEM_ADDR_R+1)'(DEPTH) << 3;
    localparam logic [CNT_W-1:0]    WAIT_LD = CNT_W'(WAIT_CYCLES);

    dmem_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gnt_q, err_q, rvld_q;

    logic                wen_q, hit_q;
    logic [MEM_STRB_R:0] strb_q;
    logic [MEM_DATA_R:0] wdata_q;
    logic [AW-1:0]       idx_q;

    logic [MEM_ADDR_R:0] offset;
    logic                hit_live;
    logic [AW-1:0]       idx_live;

    logic                use_live, acc;
    logic                a_wen, a_hit;
    logic [AW-1:0]       a_idx;
    logic [MEM_STRB_R:0] a_strb;
    logic [MEM_DATA_R:0] a_wdata;
    logic [MEM_DATA_R:0] sram_rdata;

    assign offset   = dmem_addr - BASE;
    assign hit_live = (dmem_addr >= BASE) && (offset < SPAN);
    assign idx_live = offset[3 +: AW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (dmem_req) begin
                    cnt_d   = WAIT_LD;
                    state_d = (WAIT_LD != '0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (!dmem_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the array is accessed on the capture edge, so the live bus feeds it.
    assign use_live = (state_q == ST_IDLE);
    assign acc      = (state_d == ST_RESP);
    assign a_wen    = use_live ? dmem_wen   : wen_q;
    assign a_hit    = use_live ? hit_live   : hit_q;
    assign a_idx    = use_live ? idx_live   : idx_q;
    assign a_strb   = use_live ? dmem_strb  : strb_q;
    assign a_wdata  = use_live ? dmem_wdata : wdata_q;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= acc;
            err_q   <= acc && !a_hit;
            rvld_q  <= acc && a_hit && !a_wen;
        end
    end

    always_ff @(posedge g_clk) begin
        if ((state_q == ST_IDLE) && dmem_req) begin
            wen_q   <= dmem_wen;
            hit_q   <= hit_live;
            idx_q   <= idx_live;
            strb_q  <= dmem_strb;
            wdata_q <= dmem_wdata;
        end
    end

    core_dmem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk_i   (g_clk),
        .en_i    (acc && a_hit),
        .wen_i   (a_wen),
        .idx_i   (a_idx),
        .strb_i  (a_strb),
        .wdata_i (a_wdata),
        .rdata_o (sram_rdata)
    );

    assign dmem_gnt   = gnt_q;
    assign dmem_err   = err_q;
    assign dmem_rdata = rvld_q ? sram_rdata : '0;

endmodule

// File: tb/tb_core_dmem_responder.sv
// Bench for core_dmem_responder: two instances (0 and 3 wait states) against a timing/array model.
module tb_core_dmem_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_i   [2];
    logic        wen_i   [2];
    logic [63:0] addr_i  [2];
    logic [7:0]  strb_i  [2];
    logic [63:0] wdata_i [2];
    logic        gnt_o   [2];
    logic        err_o   [2];
    logic [63:0] rdata_o [2];

    int     tests = 0;
    int     fails = 0;
    longint cyc   = 0;

    always #5 clk = ~clk;

    core_dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .g_clk(clk), .g_resetn(rst_n), .dmem_req(req_i[0]), .dmem_addr(addr_i[0]),
        .dmem_wen(wen_i[0]), .dmem_strb(strb_i[0]), .dmem_wdata(wdata_i[0]),
        .dmem_gnt(gnt_o[0]), .dmem_err(err_o[0]), .dmem_rdata(rdata_o[0]));

    core_dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(3)) u_dut3 (
        .g_clk(clk), .g_resetn(rst_n), .dmem_req(req_i[1]), .dmem_addr(addr_i[1]),
        .dmem_wen(wen_i[1]), .dmem_strb(strb_i[1]), .dmem_wdata(wdata_i[1]),
        .dmem_gnt(gnt_o[1]), .dmem_err(err_o[1]), .dmem_rdata(rdata_o[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A request seen idle at edge E is answered by the grant visible after edge E+W,
    // provided the request is still present at every edge in between.
    bit          busy [2];
    bit          resp [2];
    longint      due  [2];
    bit          exp_gnt [2];
    bit          exp_err [2];
    logic [63:0] exp_rd  [2];
    bit          c_wen   [2];
    logic [63:0] c_addr  [2];
    logic [7:0]  c_strb  [2];
    logic [63:0] c_wdata [2];
    logic [63:0] mdl_mem [2][DEPTH];
    longint      edge_n = 0;

    function automatic int wait_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    task automatic model_access(input int k);
        bit hit;
        int wi;
        hit = (c_addr[k] >= BASE) && ((c_addr[k] - BASE) < 64'(DEPTH * 8));
        resp[k]    = 1'b1;
        exp_gnt[k] = 1'b1;
        exp_err[k] = !hit;
        exp_rd[k]  = 64'd0;
        if (hit) begin
            wi = int'((c_addr[k] - BASE) / 8);
            if (c_wen[k]) begin
                for (int b = 0; b < 8; b++)
                    if (c_strb[k][b]) mdl_mem[k][wi][8*b +: 8] = c_wdata[k][8*b +: 8];
            end else begin
                exp_rd[k] = mdl_mem[k][wi];
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            exp_rd[k] = 64'd0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    busy[k] = 0; resp[k] = 0;
                    exp_gnt[k] = 0; exp_err[k] = 0; exp_rd[k] = 64'd0;
                end
            end else begin
                edge_n++;
                for (int k = 0; k < 2; k++) begin
                    exp_gnt[k] = 0; exp_err[k] = 0; exp_rd[k] = 64'd0;
                    if (resp[k]) begin
                        resp[k] = 0;
                    end else if (busy[k]) begin
                        if (!req_i[k]) busy[k] = 0;
                        else if (edge_n == due[k]) begin
                            busy[k] = 0;
                            model_access(k);
                        end
                    end else if (req_i[k]) begin
                        c_wen[k] = wen_i[k]; c_addr[k] = addr_i[k];
                        c_strb[k] = strb_i[k]; c_wdata[k] = wdata_i[k];
                        if (wait_of(k) == 0) model_access(k);
                        else begin
                            busy[k] = 1;
                            due[k]  = edge_n + wait_of(k);
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt%0d", k),   64'(gnt_o[k]), 64'(exp_gnt[k]));
            chk($sformatf("err%0d", k),   64'(err_o[k]), 64'(exp_err[k]));
            chk($sformatf("rdata%0d", k), rdata_o[k],    exp_rd[k]);
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    // Called #1 after a rising edge (cycle 0); returns #1 after the edge leaving RESP.
    task automatic xact(input int k, input logic wen, input logic [63:0] addr,
                        input logic [7:0] strb, input logic [63:0] wdata,
                        output int lat, output logic err, output logic [63:0] rdata,
                        output longint gcyc);
        bit got;
        got = 0; lat = 0; err = 1'b0; rdata = 64'd0; gcyc = 0;
        req_i[k] = 1'b1; wen_i[k] = wen; addr_i[k] = addr;
        strb_i[k] = strb; wdata_i[k] = wdata;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (gnt_o[k]) begin
                got = 1; err = err_o[k]; rdata = rdata_o[k]; gcyc = cyc;
            end else begin
                lat++;
            end
        end
        req_i[k] = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL grant_timeout: dut %0d got no grant within 20 cycles, required one", k);
        end
        @(posedge clk); #1;
    endtask

    int          lat;
    logic        e;
    logic [63:0] rd;
    longint      g1, g2;
    int          seen;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_i[k] = 0; wen_i[k] = 0; addr_i[k] = '0; strb_i[k] = '0; wdata_i[k] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt_o[0] || gnt_o[1] || err_o[0] || err_o[1] || (rdata_o[0] != 0) || (rdata_o[1] != 0))
                seen++;
        end
        chk("idle_outputs_nonzero", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // zero wait states
        xact(0, 1, 64'h10008, 8'hFF, 64'h1122334455667788, lat, e, rd, g1);
        chk("w_full_lat", 64'(lat), 64'd1);
        chk("w_full_err", 64'(e), 64'd0);
        chk("w_full_rdata", rd, 64'd0);
        xact(0, 0, 64'h10008, 8'h00, 64'd0, lat, e, rd, g1);
        chk("r_full_lat", 64'(lat), 64'd1);
        chk("r_full_rdata", rd, 64'h1122334455667788);
        xact(0, 1, 64'h10008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, lat, e, rd, g1);
        xact(0, 0, 64'h10008, 8'h00, 64'd0, lat, e, rd, g1);
        chk("r_partial_rdata", rd, 64'h11223344_BBBBBBBB);

        xact(0, 0, 64'h0FFF8, 8'h00, 64'd0, lat, e, rd, g1);
        chk("miss_low_err", 64'(e), 64'd1);
        chk("miss_low_rdata", rd, 64'd0);
        xact(0, 1, 64'h11FF8, 8'hFF, 64'hCAFEF00D_12345678, lat, e, rd, g1);
        chk("w_last_err", 64'(e), 64'd0);
        xact(0, 1, 64'h12000, 8'hFF, 64'hDEADBEEF_DEADBEEF, lat, e, rd, g1);
        chk("miss_high_err", 64'(e), 64'd1);
        xact(0, 0, 64'h11FF8, 8'h00, 64'd0, lat, e, rd, g1);
        chk("r_last_rdata", rd, 64'hCAFEF00D_12345678);
        chk("r_last_err", 64'(e), 64'd0);

        xact(0, 1, 64'h10008, 8'h00, 64'hFFFFFFFF_FFFFFFFF, lat, e, rd, g1);
        chk("w_strb0_err", 64'(e), 64'd0);
        xact(0, 0, 64'h1000F, 8'h00, 64'd0, lat, e, rd, g1);
        chk("r_strb0_rdata", rd, 64'h11223344_BBBBBBBB);

        // three wait states
        xact(1, 1, 64'h10010, 8'hFF, 64'h01234567_89ABCDEF, lat, e, rd, g1);
        chk("w3_lat", 64'(lat), 64'd4);
        xact(1, 0, 64'h10010, 8'h00, 64'd0, lat, e, rd, g1);
        chk("b2b_lat1", 64'(lat), 64'd4);
        xact(1, 0, 64'h10010, 8'h00, 64'd0, lat, e, rd, g2);
        chk("b2b_lat2", 64'(lat), 64'd4);
        chk("b2b_spacing", 64'(g2 - g1), 64'd5);
        chk("b2b_rdata", rd, 64'h01234567_89ABCDEF);

        // abort: request dropped in cycle 2 of a write
        req_i[1] = 1; wen_i[1] = 1; addr_i[1] = 64'h10010; strb_i[1] = 8'hFF;
        wdata_i[1] = 64'hFFFF0000_FFFF0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_i[1] = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (gnt_o[1]) seen++;
        end
        chk("abort_grants", 64'(seen), 64'd0);
        @(posedge clk); #1;
        xact(1, 0, 64'h10010, 8'h00, 64'd0, lat, e, rd, g1);
        chk("abort_rdata", rd, 64'h01234567_89ABCDEF);

        // reset during WAIT
        req_i[1] = 1; wen_i[1] = 0; addr_i[1] = 64'h10010;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_gnt", 64'(gnt_o[1]), 64'd0);
        chk("rst_wait_rdata", rdata_o[1], 64'd0);
        req_i[1] = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        xact(1, 0, 64'h10010, 8'h00, 64'd0, lat, e, rd, g1);
        chk("post_rst_lat", 64'(lat), 64'd4);
        chk("post_rst_rdata", rd, 64'h01234567_89ABCDEF);

        // reset while the grant is showing clears outputs at once
        req_i[0] = 1; wen_i[0] = 0; addr_i[0] = 64'h10008;
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_pre_gnt", 64'(gnt_o[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_resp_gnt", 64'(gnt_o[0]), 64'd0);
        chk("rst_resp_rdata", rdata_o[0], 64'd0);
        req_i[0] = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
